// File: rtl/bit_display_scanner.sv
// -----------------------------------------------------------------------------
// bit_display_scanner
//
// Captures a WIDTH-bit word on a ready strobe, applies one of four code
// conversions and holds the result in code_out. The converted bits are shown
// on a time-multiplexed bank of WIDTH seven-segment digits, one digit per bit,
// each digit displaying the glyph '0' or '1'. Each digit stays enabled for
// SCAN_DIV clock cycles before the scan moves on to the next digit.
//
// Conversion modes (selected by mode, sampled together with data_in):
//   0 : pass-through
//   1 : binary -> Gray
//   2 : Gray -> binary
//   3 : excess-3, (d + 3) mod 2^WIDTH
//
// Parameters:
//   WIDTH    : data bits / display digits, 2..16
//   SCAN_DIV : clock cycles per digit, >= 1
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset (highest priority)
//   data_in   in   [WIDTH] word to convert
//   mode      in   [2] conversion select
//   ready     in   load strobe
//   clear     in   blank the display (code_out is kept)
//   lamp_test in   all segments / all digits on (only with the macro below)
//   code_out  out  [WIDTH] registered converted word
//   loaded    out  one-cycle pulse after each load
//   digit_en  out  [WIDTH] one-hot digit enable, bit i shows code_out[i]
//   seg       out  [7] active-high segments, seg[0]=a .. seg[6]=g
//
// Optional feature: define BIT_DISP_LAMP_TEST_EN to add the lamp_test input.
// -----------------------------------------------------------------------------
module bit_display_scanner #(
  parameter int WIDTH    = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  input  logic             ready,
  input  logic             clear,
`ifdef BIT_DISP_LAMP_TEST_EN
  input  logic             lamp_test,
`endif
  output logic [WIDTH-1:0] code_out,
  output logic             loaded,
  output logic [WIDTH-1:0] digit_en,
  output logic [6:0]       seg
);

  localparam int IW = $clog2(WIDTH);
  // A one-bit prescaler still works for SCAN_DIV=1: it sits at 0 and wraps
  // every cycle.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(WIDTH - 1);

  localparam logic [6:0] GLYPH_ZERO = 7'b0111111;
  localparam logic [6:0] GLYPH_ONE  = 7'b0000110;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   index_q, index_d;
  logic [WIDTH-1:0] code_d;
  logic            loaded_d;
  logic [WIDTH-1:0] digit_en_d;
  logic [6:0]      seg_d;

  function automatic logic [WIDTH-1:0] convert(input logic [WIDTH-1:0] d,
                                               input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    r = d;
    unique case (m)
      2'd0: r = d;
      2'd1: r = d ^ (d >> 1);
      2'd2: begin
        r[WIDTH-1] = d[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
          r[i] = r[i+1] ^ d[i];
        end
      end
      default: r = d + WIDTH'(3);  // carry out of the top bit is dropped
    endcase
    return r;
  endfunction

  // Next-state logic. The display registers are loaded from the *next* index
  // and code so that digit_en/seg line up with code_out on the same cycle,
  // giving digit 0 in the first cycle after a load.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    presc_d    = presc_q;
    index_d    = index_q;
    code_d     = code_out;
    loaded_d   = 1'b0;
    digit_en_d = '0;
    seg_d      = '0;

    if (clear) begin
      // clear beats ready: no load, display blanks, code_out is retained.
      state_d = BLANK;
      presc_d = '0;
      index_d = '0;
    end else if (ready) begin
      state_d  = SCAN;
      presc_d  = '0;
      index_d  = '0;
      code_d   = convert(data_in, mode);
      loaded_d = 1'b1;
    end else if (state_q == SCAN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        index_d = (index_q == INDEX_LAST) ? '0 : index_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (state_d == SCAN) begin
      digit_en_d = WIDTH'(1) << index_d;
      seg_d      = code_d[index_d] ? GLYPH_ONE : GLYPH_ZERO;
    end

`ifdef BIT_DISP_LAMP_TEST_EN
    // Lamp test only overrides the display; counters keep running beneath.
    if (lamp_test) begin
      digit_en_d = '1;
      seg_d      = 7'b1111111;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BLANK;
      presc_q  <= '0;
      index_q  <= '0;
      code_out <= '0;
      loaded   <= 1'b0;
      digit_en <= '0;
      seg      <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      index_q  <= index_d;
      code_out <= code_d;
      loaded   <= loaded_d;
      digit_en <= digit_en_d;
      seg      <= seg_d;
    end
  end

endmodule
